// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order imem requests for the current PC, tags responses with
// their PC in a small ring, and hands them to decode; redirects flush and drop stale returns.
module instr_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            id_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]    head_ptr_q, head_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  // Requests accepted but not yet answered that still own a ring entry.
  logic [CW-1:0]    infl_q, infl_d;

  logic [CW-1:0]    occ;
  logic [CW-1:0]    pending;
  logic             accept, consume, rsp_drop, rsp_fill, fill_en;

  assign occ            = count_q + drop_cnt_q;
  assign imem_req_valid = rst_n & ~redirect_valid & (occ < CW'(DEPTH));
  assign imem_req_addr  = pc_in;
  assign accept         = imem_req_valid & imem_req_ready;

  assign pc_next  = redirect_valid ? (redirect_pc & ~XLEN'(3)) : (pc_in + XLEN'(4));
  assign pc_stall = ~rst_n | (~redirect_valid & ~accept);

  assign if_valid = rst_n & (count_q != '0) & filled_q[head_ptr_q];
  assign if_pc    = pc_q[head_ptr_q];
  assign if_instr = instr_q[head_ptr_q];
  assign consume  = if_valid & id_ready & ~redirect_valid;

  // Responses with nothing pending are ignored outright.
  assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
  assign rsp_fill = imem_rsp_valid & (drop_cnt_q == '0) & (infl_q != '0);
  assign fill_en  = rst_n & rsp_fill & ~redirect_valid;

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    drop_cnt_d  = drop_cnt_q;
    infl_d      = infl_q;
    filled_d    = filled_q;
    pending     = drop_cnt_q + infl_q;
    if (redirect_valid) begin
      if (imem_rsp_valid && (pending != '0)) pending = pending - CW'(1);
      drop_cnt_d  = pending;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      infl_d      = '0;
      filled_d    = '0;
    end else begin
      count_d     = count_q + CW'(accept) - CW'(consume);
      infl_d      = infl_q + CW'(accept) - CW'(rsp_fill);
      drop_cnt_d  = drop_cnt_q - CW'(rsp_drop);
      alloc_ptr_d = alloc_ptr_q + PW'(accept);
      fill_ptr_d  = fill_ptr_q + PW'(rsp_fill);
      head_ptr_d  = head_ptr_q + PW'(consume);
      if (consume)  filled_d[head_ptr_q] = 1'b0;
      if (rsp_fill) filled_d[fill_ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
      infl_q      <= '0;
      filled_q    <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      infl_q      <= infl_d;
      filled_q    <= filled_d;
    end
  end

  // Payload storage carries no reset; the filled bits qualify it.
  always_ff @(posedge clk) begin
    if (accept)  pc_q[alloc_ptr_q]   <= pc_in;
    if (fill_en) instr_q[fill_ptr_q] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: bench-side PC register and in-order memory model,
// directed phases push expected decode PCs; a negedge monitor pops and compares.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic [XLEN-1:0] pc_next;
  logic            pc_stall;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b1;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready = 1'b0;

  instr_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_next(pc_next), .pc_stall(pc_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          consumed = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] pc_nxt_v = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // PC register model: load pc_next unless stalled; reset value 0.
  always @(negedge clk) pc_nxt_v = !rst_n ? 32'h0 : (pc_stall ? pc_in : pc_next);

  // In-order memory: one response per accepted request, lat cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) mq.push_back('{addr: imem_req_addr, due: cyc + lat});
    end
  end

  // Decode-side monitor; a handshake in a redirect cycle is absorbed by the flush.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_decode: got pc 0x%08h, expected no instruction", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("decode_pc", if_pc, e);
        chk("decode_instr", if_instr, instr_of(e));
      end
      consumed++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pc_in = pc_nxt_v;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.delete();
    consumed = 0;
    step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_pc_stall", {31'b0, pc_stall}, 32'h1);
    step();
  endtask

  task automatic wait_consumed(input int n, input int budget, input string name);
    int k = 0;
    while (consumed < n && k < budget) begin
      step();
      k++;
    end
    id_ready = 1'b0;
    chk(name, consumed, n);
    chk({name, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset then stream with 1-cycle memory.
    do_reset();
    lat = 1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    rst_n = 1'b1;
    id_ready = 1'b1;
    #1;
    chk("p1_c0_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("p1_c0_req_addr", imem_req_addr, 32'h0);
    chk("p1_c0_pc_stall", {31'b0, pc_stall}, 32'h0);
    chk("p1_c0_pc_next", pc_next, 32'h4);
    step();
    chk("p1_c1_req_addr", imem_req_addr, 32'h4);
    step();
    chk("p1_c2_if_valid", {31'b0, if_valid}, 32'h1);
    chk("p1_c2_if_pc", if_pc, 32'h0);
    wait_consumed(6, 40, "p1_stream");

    // Decode backpressure for 5 cycles.
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8};
    rst_n = 1'b1;
    #1;
    step();
    chk("p2_c1_req_valid", {31'b0, imem_req_valid}, 32'h1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("p2_full_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("p2_full_pc_stall", {31'b0, pc_stall}, 32'h1);
      chk("p2_hold_if_valid", {31'b0, if_valid}, 32'h1);
      chk("p2_hold_if_pc", if_pc, 32'h0);
      chk("p2_hold_if_instr", if_instr, instr_of(32'h0));
    end
    step();
    id_ready = 1'b1;
    wait_consumed(3, 40, "p2_release");

    // Redirect with two responses in flight, 3-cycle memory.
    do_reset();
    lat = 3;
    exp_q = '{32'h100, 32'h104};
    rst_n = 1'b1;
    id_ready = 1'b1;
    #1;
    step();
    chk("p3_c1_req_valid", {31'b0, imem_req_valid}, 32'h1);
    step();
    chk("p3_c2_req_valid", {31'b0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("p3_redir_pc_next", pc_next, 32'h100);
    chk("p3_redir_pc_stall", {31'b0, pc_stall}, 32'h0);
    chk("p3_redir_req_valid", {31'b0, imem_req_valid}, 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("p3_c3_req_valid", {31'b0, imem_req_valid}, 32'h0);
    step();
    chk("p3_c4_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("p3_c4_req_addr", imem_req_addr, 32'h100);
    wait_consumed(2, 40, "p3_after_flush");

    // Misaligned redirect, then address wrap.
    do_reset();
    lat = 1;
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    rst_n = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("p4_misalign_pc_next", pc_next, 32'h100);
    chk("p4_redir_req_valid", {31'b0, imem_req_valid}, 32'h0);
    step();
    redirect_pc = 32'hFFFF_FFFA;
    #1;
    chk("p4_redir2_pc_next", pc_next, 32'hFFFF_FFF8);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("p4_c2_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    chk("p4_c2_pc_next", pc_next, 32'hFFFF_FFFC);
    step();
    chk("p4_wrap_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("p4_wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("p4_wrap_pc_next", pc_next, 32'h0);
    chk("p4_wrap_pc_stall", {31'b0, pc_stall}, 32'h0);
    wait_consumed(4, 40, "p4_wrap_stream");

    // Redirect coincident with a response and a consume.
    do_reset();
    exp_q = '{32'h200, 32'h204};
    rst_n = 1'b1;
    id_ready = 1'b1;
    #1;
    step();
    step();
    chk("p5_c2_if_valid", {31'b0, if_valid}, 32'h1);
    chk("p5_c2_if_pc", if_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("p5_redir_pc_next", pc_next, 32'h200);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("p5_post_if_valid", {31'b0, if_valid}, 32'h0);
    chk("p5_post_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("p5_post_req_addr", imem_req_addr, 32'h200);
    wait_consumed(2, 40, "p5_after_flush");

    // Memory not ready for 4 cycles.
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8};
    rst_n = 1'b1;
    id_ready = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("p6_stall_pc_stall", {31'b0, pc_stall}, 32'h1);
      chk("p6_stall_pc_next", pc_next, 32'h4);
      chk("p6_stall_req_addr", imem_req_addr, 32'h0);
      chk("p6_stall_if_valid", {31'b0, if_valid}, 32'h0);
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    chk("p6_resume_req_addr", imem_req_addr, 32'h0);
    chk("p6_resume_pc_stall", {31'b0, pc_stall}, 32'h0);
    wait_consumed(3, 40, "p6_resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
